mul_div_unit: RTL and testbench

Multi-cycle integer multiply/divide unit with architectural HI/LO registers for the single-cycle CPU's execute stage. It consumes the register-file read operands (RS, RT) alongside the ALU and serves MIPS mult, multu, div, divu, mthi and mtlo. Results are read back by mfhi/mflo from `hi_o`/`lo_o`. `busy_o` stalls PC update while an operation is in flight.

---
 rtl/mul_div_unit.sv | 197 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle 32-bit multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up in FIN.
module mul_div_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_zero_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sgn1_q, sgn1_d;
  logic        sgn2_q, sgn2_d;
  logic        dz_flag_q, dz_flag_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;

  logic        in_signed_s;
  logic [31:0] abs1_s, abs2_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_shift_s;
  logic        div_ge_s;
  logic [31:0] div_sub_s;
  logic [63:0] prod_s, prod_neg_s;
  logic        neg_res_s, neg_rem_s;

  // Magnitudes are taken at capture so the iterations are purely unsigned.
  assign in_signed_s = ~op_i[0];
  assign abs1_s      = (in_signed_s && src1_i[31]) ? (32'd0 - src1_i) : src1_i;
  assign abs2_s      = (in_signed_s && src2_i[31]) ? (32'd0 - src2_i) : src2_i;

  // Multiply: acc_hi accumulates, acc_lo holds the multiplier and collects product low bits.
  assign mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift_s = {acc_hi_q, acc_lo_q[31]};
  assign div_ge_s    = (div_shift_s >= {1'b0, opb_q});
  assign div_sub_s   = div_shift_s[31:0] - opb_q;

  assign prod_s      = {acc_hi_q, acc_lo_q};
  assign prod_neg_s  = 64'd0 - prod_s;
  assign neg_res_s   = ~op_q[0] & (sgn1_q ^ sgn2_q);
  assign neg_rem_s   = ~op_q[0] & sgn1_q;

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sgn1_d     = sgn1_q;
    sgn2_d     = sgn2_q;
    dz_flag_d  = dz_flag_q;
    opb_d      = opb_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we_i) begin
          hi_d = wdata_i;
        end else begin
          hi_d = hi_q;
        end
        if (lo_we_i) begin
          lo_d = wdata_i;
        end else begin
          lo_d = lo_q;
        end
        if (start_i) begin
          op_d     = op_i;
          sgn1_d   = src1_i[31];
          sgn2_d   = src2_i[31];
          cnt_d    = 5'd0;
          acc_hi_d = 32'd0;
          if (op_i[1]) begin
            acc_lo_d = abs1_s;
            opb_d    = abs2_s;
            if (src2_i == 32'd0) begin
              dz_flag_d = 1'b1;
              state_d   = S_FIN;
            end else begin
              dz_flag_d = 1'b0;
              state_d   = S_CALC;
            end
          end else begin
            acc_lo_d  = abs2_s;
            opb_d     = abs1_s;
            dz_flag_d = 1'b0;
            state_d   = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (op_q[1]) begin
          if (div_ge_s) begin
            acc_hi_d = div_sub_s;
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = div_shift_s[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum_s[32:1];
          acc_lo_d = {mul_sum_s[0], acc_lo_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIN;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_flag_q) begin
          div_zero_d = 1'b1;
        end else if (op_q[1]) begin
          lo_d = neg_res_s ? (32'd0 - acc_lo_q) : acc_lo_q;
          hi_d = neg_rem_s ? (32'd0 - acc_hi_q) : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_res_s ? prod_neg_s : prod_s;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      op_q       <= 2'd0;
      sgn1_q     <= 1'b0;
      sgn2_q     <= 1'b0;
      dz_flag_q  <= 1'b0;
      opb_q      <= 32'd0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sgn1_q     <= sgn1_d;
      sgn2_q     <= sgn2_d;
      dz_flag_q  <= dz_flag_d;
      opb_q      <= opb_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed cases plus random operations
// checked against a plain-arithmetic model of HI/LO.
module tb_mul_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, hi_we_i, lo_we_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i, src2_i, wdata_i;
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  mul_div_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        scb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  int          dones = 0;
  logic        prev_done = 1'b0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk_i) begin
    if (rst_i !== 1'b1) begin
      if (div_zero_o === 1'b1 && done_o !== 1'b1) check("dz_without_done", 64'(done_o), 64'd1);
      if (done_o === 1'b1) begin
        dones++;
        check("done_width", 64'(prev_done), 64'd0);
        if (scb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done with empty queue expected none");
        end else begin
          mon_e = scb.pop_front();
          check("hi", 64'(hi_o), 64'(mon_e.hi));
          check("lo", 64'(lo_o), 64'(mon_e.lo));
          check("div_zero", 64'(div_zero_o), 64'(mon_e.dz));
        end
      end
      prev_done = done_o;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz);
    exp_t e;
    int   n, busy_n;
    e.hi = eh; e.lo = el; e.dz = edz;
    scb.push_back(e);
    model_hi = eh;
    model_lo = el;
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0; busy_n = 0;
    while (done_o !== 1'b1 && n < 45) begin
      if (busy_o === 1'b1) busy_n++;
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 45) check("done_timeout", 64'(n), 64'd34);
    else check("busy_cycles", 64'(busy_n), edz ? 64'd1 : 64'd33);
  endtask

  // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] eh, el;
    logic        dz;
    sa = $signed(a); sb = $signed(b);
    eh = model_hi; el = model_lo; dz = 1'b0;
    case (op)
      2'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
      2'd2: begin
        if (b == 32'd0) dz = 1'b1;
        else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) dz = 1'b1;
        else begin el = a / b; eh = a % b; end
      end
    endcase
    run_op(op, a, b, eh, el, dz);
  endtask

  task automatic write_reg(input logic h, input logic l, input logic [31:0] d);
    hi_we_i = h; lo_we_i = l; wdata_i = d;
    @(posedge clk_i); #1;
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    if (h) begin model_hi = d; check("mthi", 64'(hi_o), 64'(d)); end
    if (l) begin model_lo = d; check("mtlo", 64'(lo_o), 64'(d)); end
  endtask

  initial begin
    int d0;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst_i = 1'b1; start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    op_i = 2'd0; src1_i = 32'd0; src2_i = 32'd0; wdata_i = 32'd0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_dz", 64'(div_zero_o), 64'd0);

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op(2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);

    write_reg(1'b1, 1'b0, 32'h1234);
    write_reg(1'b0, 1'b1, 32'h5678);
    run_op(2'd3, 32'd100, 32'd0, 32'h1234, 32'h5678, 1'b1);
    write_reg(1'b1, 1'b1, 32'hCAFE0001);

    // Start and mtlo while busy must both be ignored.
    d0 = dones;
    fork
      run_op(2'd1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
      begin
        repeat (5) @(posedge clk_i);
        #2 start_i = 1'b1; op_i = 2'd2; src1_i = 32'd9; src2_i = 32'd3;
        @(posedge clk_i);
        #2 start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2 lo_we_i = 1'b1; wdata_i = 32'hAAAA;
        @(posedge clk_i);
        #2 lo_we_i = 1'b0;
      end
    join
    repeat (40) @(posedge clk_i);
    #1 check("single_done", 64'(dones - d0), 64'd1);

    // Reset mid-operation: no done, HI/LO cleared.
    start_i = 1'b1; op_i = 2'd0; src1_i = 32'd6; src2_i = 32'd7;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (11) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    check("abort_hi", 64'(hi_o), 64'd0);
    check("abort_lo", 64'(lo_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    model_hi = 32'd0; model_lo = 32'd0;
    d0 = dones;
    repeat (40) @(posedge clk_i);
    #1 check("abort_no_done", 64'(dones - d0), 64'd0);
    run_op(2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h000000FF;
      if ($urandom_range(0, 6) == 0) rb = 32'd0;
      if ($urandom_range(0, 6) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 5) == 0) write_reg(1'($urandom_range(0, 1)), 1'b1, $urandom);
      model_op(rop, ra, rb);
    end
    model_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    model_op(2'd0, 32'h80000000, 32'h80000000);

    repeat (3) @(posedge clk_i);
    #1 check("queue_empty", 64'(scb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
